// File: rtl/dpram_stream_reader.sv
// Burst reader for one port of a 1-cycle-latency dual-port RAM, presented as a valid/ready stream.
// Optional end-of-burst marker m_last is built when DPRAM_READER_LAST_EN is defined.
module dpram_stream_reader #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDRESS_WIDTH = 10,
  parameter int LEN_WIDTH     = ADDRESS_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]     length,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_dout,
`ifdef DPRAM_READER_LAST_EN
  output logic                     m_last,
`endif
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]     r_issue_left;
  logic                     r_inflight;
  logic [DATA_WIDTH-1:0]    r_fifo [2];
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_count;
`ifdef DPRAM_READER_LAST_EN
  logic [LEN_WIDTH-1:0]     r_beats_left;
`endif

  logic       w_push;
  logic       w_pop;
  logic [2:0] w_occupancy;
  logic       w_issue;
  logic [1:0] w_count_next;

  // A read may issue only if its word is guaranteed a FIFO slot when it returns,
  // counting the word already in flight and crediting a beat leaving this cycle.
  assign w_push       = r_inflight;
  assign w_pop        = (r_count != 2'd0) && m_ready;
  assign w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_READ) && (w_occupancy < 3'd2);
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_en   = w_issue;
  assign mem_addr = r_addr;
  assign m_valid  = (r_count != 2'd0);
  assign m_data   = r_fifo[r_rd_ptr];
`ifdef DPRAM_READER_LAST_EN
  assign m_last   = m_valid && (r_beats_left == LEN_WIDTH'(1));
`endif

  // NOTE: all state here updates with non-blocking assignments so every read of a
  // register in this block sees its value from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_inflight   <= 1'b0;
      // NOTE: the buffer is two plain registers, not a RAM macro, so clearing it is
      // cheap and keeps m_data at zero after reset.
      r_fifo[0]    <= '0;
      r_fifo[1]    <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
`ifdef DPRAM_READER_LAST_EN
      r_beats_left <= '0;
`endif
    end else begin
      r_inflight <= w_issue;
      r_count    <= w_count_next;
      r_done     <= 1'b0;

      if (w_issue) begin
        r_addr       <= r_addr + 1'b1;
        r_issue_left <= r_issue_left - 1'b1;
      end

      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_dout;
        r_wr_ptr         <= ~r_wr_ptr;
      end

      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
`ifdef DPRAM_READER_LAST_EN
        r_beats_left <= r_beats_left - 1'b1;
`endif
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr       <= base_addr;
            r_issue_left <= length;
`ifdef DPRAM_READER_LAST_EN
            r_beats_left <= length;
`endif
            if (length == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_busy  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (w_issue && (r_issue_left == LEN_WIDTH'(1))) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Nothing issues here, so an empty next-cycle buffer means the last beat just left;
          // looking ahead lets done follow that beat by exactly one cycle.
          if (w_count_next == 2'd0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
